am29_scan_decoder: RTL and testbench
====================================

# am29_scan_decoder

Parametrised, registered 1-of-2^SEL_W decoder/demultiplexer with an address latch and an autonomous scan mode. It succeeds the 3-to-8 combinational decoder family. It drives active-low strobes for display/keyboard scanning, memory bank selects or microcode-phase strobes. In addressed mode it behaves as a latched decoder. In scan mode it steps through all outputs with a programmable dwell time.

## Interface
Parameters:
- SEL_W, 3, select width; output count is 2^SEL_W (legal 1..6)
- DWELL_W, 4, width of the dwell register

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_  in  1  synchronous, active-low reset
- sel  in  SEL_W  address to latch
- le_  in  1  latch enable, active low; sampled at clk
- g1  in  1  enable, active high
- g2a_, g2b_  in  1 each  enables, active low
- mode  in  1  0 = addressed, 1 = scan
- dwell  in  DWELL_W  cycles per scan step minus 1
- y_  out  2^SEL_W  registered active-low one-hot strobes
- cur  out  SEL_W  registered current index
- wrap  out  1  one-cycle pulse when the scan returns to index 0

## Operation
- Gate: g = g1 & ~g2a_ & ~g2b_, sampled at clk.
- Reset (rst_ low at edge):
  - idx = 0, cnt = 0, blank = 0
  - y_ = all ones, cur = 0, wrap = 0
  - Reset applied mid-scan aborts the step immediately.
- Priority per edge: reset > latch > scan step > hold.
- Latch: le_ low sets idx = sel and cnt = 0 in either mode. In scan mode this is a jump; scanning continues from sel. No wrap pulse is generated by a latch, even if sel = 0.
- Addressed mode (mode = 0): idx changes only on latch; cnt is held at 0.
- Scan mode (mode = 1), with le_ high:
  - cnt increments each cycle.
  - When cnt >= dwell: cnt = 0 and idx = idx + 1 modulo 2^SEL_W (wrap-around from all ones to 0).
  - The >= compare means lowering dwell mid-step ends the current step on the next edge.
- Mode switching:
  - 1 -> 0: freeze idx, clear cnt.
  - 0 -> 1: start counting from the current idx with cnt = 0.
- Output: y_[i] = ~(g & (idx == i)). g = 0 forces all ones but does not stop the scan counter.
- wrap is asserted in the first cycle y_/cur present index 0 after an idx increment from 2^SEL_W-1.

## Timing
- All outputs are registered. Latency from the sampled sel/le_/g/mode to y_/cur is 1 cycle.
- Each scan index is visible for dwell+1 cycles (without blanking).
- dwell = 0 steps every cycle.
- wrap is exactly 1 cycle wide and is never asserted in addressed mode.
- A latch and a step in the same cycle: the latch wins; cnt = 0.

## Configuration
- AM29_SCAN_BLANK_EN defined:
  - Each scan step inserts one break-before-make cycle. In the cycle after the step edge, y_ = all ones while cur already shows the new index. The new strobe asserts one cycle later.
  - Period per index is dwell+2.
  - wrap aligns with the first cycle y_ shows index 0.
  - Latches do not blank.
- Undefined: no blank cycle; period is dwell+1; the blank register is absent.

## Structure
- Package am29_dec_pkg holds:
  - mode constants MODE_ADDR = 1'b0 and MODE_SCAN = 1'b1
  - function onehot_n(idx, gate) returning the active-low decode
- Sub-module am29_dec_core: purely combinational SEL_W-to-2^SEL_W active-low decoder with gate input, reused by the top.
- The top holds idx, cnt, the optional blank flag, and the output registers.

## Test plan
- Reset: hold rst_ low 3 cycles with mode = 1 -> y_ = 8'hFF, cur = 0, wrap = 0. After release, first step occurs after dwell+1 cycles.
- Addressed: mode = 0, g enabled, sel = 5, le_ pulse -> next cycle y_ = 8'hDF, cur = 5. Hold for 10 cycles with le_ high; sel changes are ignored.
- Gating: idx = 3, g2a_ = 1 -> y_ = 8'hFF next cycle, and cur stays 3. With mode = 1, the scan keeps advancing while gated.
- Scan wrap: mode = 1, dwell = 2, start at idx 6 -> indices 6,6,6,7,7,7,0,... wrap is high only in the first 0 cycle. With AM29_SCAN_BLANK_EN, a blank cycle (y_ = FF) precedes 7 and 0.
- Jump/priority: scanning at idx 2 with cnt = dwell, le_ low and sel = 0 in the same cycle -> idx = 0, cnt = 0, wrap = 0.
- Dwell change: dwell 7 -> 1 while cnt = 4 -> step on the next edge, then 2-cycle steps.

Source files
------------

// File: rtl/am29_dec_pkg.sv
// am29_dec_pkg
// Shared constants and decode helper for the am29 scan decoder family.
//   MODE_ADDR / MODE_SCAN : values of the mode input
//   onehot_n(idx, gate)   : active-low one-hot decode of a 6-bit index, all
//                           ones when gate is low; callers slice the low
//                           2^SEL_W bits they need.
package am29_dec_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  localparam int unsigned MAX_SEL_W = 6;

  function automatic logic [63:0] onehot_n(input logic [5:0] idx, input logic gate);
    logic [63:0] dec;
    dec      = 64'd0;
    dec[idx] = gate;
    return ~dec;
  endfunction

endpackage

// File: rtl/am29_scan_decoder_if.sv
// am29_scan_decoder_if
// Bus bundle between the decoder and its controller.
//   sel, le_        : address and active-low latch enable
//   g1, g2a_, g2b_  : output gate (g1 & ~g2a_ & ~g2b_)
//   mode, dwell     : addressed/scan select, cycles per scan step minus 1
//   y_, cur, wrap   : registered active-low strobes, current index, wrap pulse
// master drives the controls, slave is the decoder.
interface am29_scan_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
);
  localparam int N = 1 << SEL_W;

  logic [SEL_W-1:0]   sel;
  logic               le_;
  logic               g1;
  logic               g2a_;
  logic               g2b_;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0]       y_;
  logic [SEL_W-1:0]   cur;
  logic               wrap;

  modport master (
    output sel, le_, g1, g2a_, g2b_, mode, dwell,
    input  y_, cur, wrap
  );

  modport slave (
    input  sel, le_, g1, g2a_, g2b_, mode, dwell,
    output y_, cur, wrap
  );

endinterface

// File: rtl/am29_dec_core.sv
// am29_dec_core
// Combinational SEL_W-to-2^SEL_W active-low decoder with a gate input.
//   idx  : index to decode
//   gate : high enables the selected strobe, low forces all ones
//   y_n  : active-low one-hot strobes
module am29_dec_core
  import am29_dec_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      idx,
  input  logic                  gate,
  output logic [(1<<SEL_W)-1:0] y_n
);

  localparam int N = 1 << SEL_W;

  logic [63:0] dec_full;
  logic        unused_hi;

  assign dec_full  = onehot_n(6'(idx), gate);
  assign y_n       = dec_full[N-1:0];
  // Upper decode bits are beyond 2^SEL_W and always one; fold them away.
  assign unused_hi = ^dec_full;

endmodule

// File: rtl/am29_scan_decoder.sv
// am29_scan_decoder
// Registered 1-of-2^SEL_W active-low decoder with address latch and an
// autonomous scan mode that steps through all outputs every dwell+1 cycles.
//   clk  : clock, all state changes on the rising edge
//   rst_ : synchronous active-low reset
//   bus  : am29_scan_decoder_if slave (sel, le_, g1, g2a_, g2b_, mode, dwell
//          in; y_, cur, wrap out)
// Build option AM29_SCAN_BLANK_EN: each scan step inserts one
// break-before-make cycle (y_ all ones, cur already new); the scan period
// becomes dwell+2 and wrap moves to the first cycle y_ shows index 0.
module am29_scan_decoder
  import am29_dec_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                clk,
  input  logic                rst_,
  am29_scan_decoder_if.slave  bus
);

  localparam int N = 1 << SEL_W;
  localparam logic [SEL_W-1:0] IDX_LAST = {SEL_W{1'b1}};

  logic [SEL_W-1:0]   idx, idx_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic               gate, latch, scan, step, hold, strobe_en, wrap_nxt;
  logic [N-1:0]       y_nxt, y_q;
  logic [SEL_W-1:0]   cur_q;
  logic               wrap_q;

  assign gate  = bus.g1 & ~bus.g2a_ & ~bus.g2b_;
  assign latch = ~bus.le_;
  assign scan  = (bus.mode == MODE_SCAN);
  // >= so that lowering dwell mid-step ends the step on the next edge.
  assign step  = scan & ~latch & ~hold & (cnt >= bus.dwell);

`ifdef AM29_SCAN_BLANK_EN
  logic blank;

  always_ff @(posedge clk) begin
    if (!rst_) blank <= 1'b0;
    else       blank <= step;
  end

  // The blank cycle freezes the counter so the period stretches to dwell+2.
  assign hold      = blank;
  assign strobe_en = ~step;
  // Only steps blank, and the only step landing on 0 is a wrap; report it
  // when the strobe for index 0 actually appears.
  assign wrap_nxt  = blank & scan & ~latch & (idx == '0);
`else
  assign hold      = 1'b0;
  assign strobe_en = 1'b1;
  assign wrap_nxt  = step & (idx == IDX_LAST);
`endif

  always_comb begin
    idx_nxt = idx;
    cnt_nxt = cnt;
    if (latch) begin
      idx_nxt = bus.sel;
      cnt_nxt = '0;
    end else if (!scan) begin
      cnt_nxt = '0;
    end else if (hold) begin
      cnt_nxt = cnt;
    end else if (step) begin
      idx_nxt = idx + 1'b1;
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  am29_dec_core #(.SEL_W(SEL_W)) u_core (
    .idx  (idx_nxt),
    .gate (gate & strobe_en),
    .y_n  (y_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_) begin
      idx    <= '0;
      cnt    <= '0;
      y_q    <= '1;
      cur_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      y_q    <= y_nxt;
      cur_q  <= idx_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.y_   = y_q;
  assign bus.cur  = cur_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_am29_scan_decoder.sv
module tb_am29_scan_decoder;

`ifdef AM29_SCAN_BLANK_EN
  localparam int BLANK = 1;
`else
  localparam int BLANK = 0;
`endif

  logic clk = 1'b0;
  logic rst_;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  am29_scan_decoder_if #(.SEL_W(3), .DWELL_W(4)) bus ();

  am29_scan_decoder #(.SEL_W(3), .DWELL_W(4)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  typedef struct {
    logic       rst_;
    logic [2:0] sel;
    logic       le_;
    logic       g1;
    logic       g2a_;
    logic       g2b_;
    logic       mode;
    logic [3:0] dwell;
    logic [7:0] ey;
    logic [2:0] ecur;
    logic       ewrap;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ey, input logic [2:0] ecur,
                         input logic ewrap);
    chk({tag, " y_"},   32'(bus.y_),   32'(ey));
    chk({tag, " cur"},  32'(bus.cur),  32'(ecur));
    chk({tag, " wrap"}, 32'(bus.wrap), 32'(ewrap));
  endtask

  // Expected outputs t edges after a reference edge at which idx = s and
  // cnt = 0 (latch, reset release or mode entry), with constant dwell d.
  // First step lands at t = d+1, later steps every d+1+BLANK edges.
  function automatic void exp_scan(input int s, input int d, input int t,
                                   output int e_cur, output logic [7:0] e_y,
                                   output logic e_wrap);
    int first, p, ph;
    first  = d + 1;
    p      = d + 1 + BLANK;
    e_wrap = 1'b0;
    if (t < first) begin
      e_cur = s % 8;
      ph    = -1;
    end else begin
      e_cur = (s + 1 + (t - first) / p) % 8;
      ph    = (t - first) % p;
    end
    e_y = ~(8'd1 << e_cur);
    if (BLANK == 1 && ph == 0) e_y = 8'hFF;
    if (e_cur == 0 && ph == BLANK) e_wrap = 1'b1;
  endfunction

  task automatic run_scan(input string tag, input int s, input int d, input int t0,
                          input int t1, input bit gated);
    int         ec;
    logic [7:0] ey;
    logic       ew;
    for (int t = t0; t <= t1; t++) begin
      tick();
      exp_scan(s, d, t, ec, ey, ew);
      if (gated) ey = 8'hFF;
      chk_out($sformatf("%s t%0d", tag, t), ey, 3'(ec), ew);
    end
  endtask

  initial begin
    int         ec;
    logic [7:0] ey;
    logic       ew;
    int         frozen;

    //           rst  sel   le_  g1    g2a_  g2b_  mode  dwell  y_      cur   wrap
    vecs[0]  = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 8'hFF, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 8'hFF, 3'd0, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'hFF, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 8'hDF, 3'd5, 1'b0};
    vecs[4]  = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 8'hDF, 3'd5, 1'b0};
    vecs[5]  = '{1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'hDF, 3'd5, 1'b0};
    vecs[6]  = '{1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'hFF, 3'd5, 1'b0};
    vecs[7]  = '{1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'hFF, 3'd5, 1'b0};
    vecs[8]  = '{1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'hFF, 3'd5, 1'b0};
    vecs[9]  = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'hF7, 3'd3, 1'b0};
    vecs[10] = '{1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'hFF, 3'd3, 1'b0};
    vecs[11] = '{1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'hFE, 3'd0, 1'b0};
    vecs[12] = '{1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h7F, 3'd7, 1'b0};
    vecs[13] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h7F, 3'd7, 1'b0};
    vecs[14] = '{1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'hFF, 3'd0, 1'b0};

    rst_      = 1'b0;
    bus.sel   = '0;
    bus.le_   = 1'b1;
    bus.g1    = 1'b1;
    bus.g2a_  = 1'b0;
    bus.g2b_  = 1'b0;
    bus.mode  = 1'b1;
    bus.dwell = 4'd2;

    for (int i = 0; i < 15; i++) begin
      rst_      = vecs[i].rst_;
      bus.sel   = vecs[i].sel;
      bus.le_   = vecs[i].le_;
      bus.g1    = vecs[i].g1;
      bus.g2a_  = vecs[i].g2a_;
      bus.g2b_  = vecs[i].g2b_;
      bus.mode  = vecs[i].mode;
      bus.dwell = vecs[i].dwell;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].ey, vecs[i].ecur, vecs[i].ewrap);
    end

    // Reset held 3 cycles in scan mode, then first step after dwell+1 edges.
    rst_ = 1'b0; bus.mode = 1'b1; bus.dwell = 4'd2; bus.le_ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("rst%0d", i), 8'hFF, 3'd0, 1'b0);
    end
    rst_ = 1'b1;
    run_scan("rel", 0, 2, 1, 5, 1'b0);

    // Addressed: latch 5, then ignore sel for 10 cycles.
    bus.mode = 1'b0; bus.le_ = 1'b0; bus.sel = 3'd5;
    tick();
    chk_out("addr latch", 8'hDF, 3'd5, 1'b0);
    bus.le_ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.sel = 3'(i);
      tick();
      chk_out($sformatf("addr hold%0d", i), 8'hDF, 3'd5, 1'b0);
    end

    // Gating: idx 3 gated off, then scan keeps advancing while gated.
    bus.le_ = 1'b0; bus.sel = 3'd3;
    tick();
    chk_out("gate latch", 8'hF7, 3'd3, 1'b0);
    bus.le_ = 1'b1; bus.g2a_ = 1'b1;
    tick();
    chk_out("gate off", 8'hFF, 3'd3, 1'b0);
    tick();
    chk_out("gate off2", 8'hFF, 3'd3, 1'b0);
    bus.mode = 1'b1; bus.dwell = 4'd1;
    run_scan("gscan", 3, 1, 1, 6, 1'b1);
    bus.g2a_ = 1'b0;
    run_scan("gscan on", 3, 1, 7, 9, 1'b0);

    // Scan wrap from idx 6 with dwell 2.
    bus.le_ = 1'b0; bus.sel = 3'd6; bus.dwell = 4'd2;
    tick();
    chk_out("wrap latch", 8'hBF, 3'd6, 1'b0);
    bus.le_ = 1'b1;
    run_scan("wrap", 6, 2, 1, 12, 1'b0);

    // Latch to 0 coincident with a due step: latch wins, no wrap.
    bus.le_ = 1'b0; bus.sel = 3'd2; bus.dwell = 4'd3;
    tick();
    chk_out("jump start", 8'hFB, 3'd2, 1'b0);
    bus.le_ = 1'b1;
    run_scan("jump pre", 2, 3, 1, 3, 1'b0);
    bus.le_ = 1'b0; bus.sel = 3'd0;
    tick();
    chk_out("jump", 8'hFE, 3'd0, 1'b0);
    bus.le_ = 1'b1;
    run_scan("jump post", 0, 3, 1, 5, 1'b0);

    // Dwell lowered from 7 to 1 with cnt = 4: step on the next edge.
    bus.le_ = 1'b0; bus.sel = 3'd4; bus.dwell = 4'd7;
    tick();
    chk_out("dwell latch", 8'hEF, 3'd4, 1'b0);
    bus.le_ = 1'b1;
    run_scan("dwell7", 4, 7, 1, 4, 1'b0);
    bus.dwell = 4'd1;
    run_scan("dwell1", 4, 1, 2, 8, 1'b0);

    // Scan -> addressed freezes idx; addressed -> scan restarts with cnt = 0.
    exp_scan(4, 1, 8, ec, ey, ew);
    frozen = ec;
    bus.mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("freeze%0d", i), ~(8'd1 << frozen), 3'(frozen), 1'b0);
    end
    bus.mode = 1'b1;
    run_scan("resume", frozen, 1, 1, 5, 1'b0);

    // Reset mid-scan aborts the step.
    rst_ = 1'b0;
    tick();
    chk_out("mid rst", 8'hFF, 3'd0, 1'b0);
    rst_ = 1'b1;
    run_scan("post rst", 0, 1, 1, 3, 1'b0);

    // dwell = 0 steps every cycle through the wrap.
    bus.le_ = 1'b0; bus.sel = 3'd7; bus.dwell = 4'd0;
    tick();
    chk_out("d0 latch", 8'h7F, 3'd7, 1'b0);
    bus.le_ = 1'b1;
    run_scan("d0", 7, 0, 1, 10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
